// File: rtl/mem_stage_access_unit_if.sv
// EX/MEM-to-data-memory bus: request fields from the pipeline register and
// the load result / hold signals returned to the pipeline.
interface mem_stage_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              MemWrite;
  logic              MemRead;
  logic              C_EN;
  logic [ADDR_W-1:0] Count;
  logic [31:0]       Addr;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;
  logic              Stall;
  logic              Done;

  modport master (
    output MemWrite, MemRead, C_EN, Count, Addr, WriteData,
    input  ReadData, Stall, Done
  );

  modport slave (
    input  MemWrite, MemRead, C_EN, Count, Addr, WriteData,
    output ReadData, Stall, Done
  );
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data memory: single-cycle word load/store plus a stalling
// multi-cycle block-sum of Count+1 consecutive words.
module mem_stage_access_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input logic Clk,
  input logic Rst,
  mem_stage_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] acc;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;

  logic [ADDR_W-1:0] word_idx;
  logic              sum_start;
  logic              mem_we;
  logic              addr_unused;

  assign word_idx    = bus.Addr[ADDR_W+1:2];
  assign addr_unused = ^{bus.Addr[31:ADDR_W+2], bus.Addr[1:0]};
  assign sum_start   = (state == IDLE) && bus.MemRead && bus.C_EN;
  // Stores only from IDLE, never alongside a load, never while reset is held.
  assign mem_we      = Rst && (state == IDLE) && bus.MemWrite && !bus.MemRead;

  // Memory array: written at the edge, intentionally not reset.
  always_ff @(posedge Clk) begin
    if (mem_we)
      mem[word_idx] <= bus.WriteData;
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: burst start, run until remaining hits zero, one DONE cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (sum_start) state_next = SUM;
      SUM:     if (remaining == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Block-sum datapath: capture operands at start, accumulate one word per SUM cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      acc       <= '0;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sum_start) begin
            acc       <= '0;
            ptr       <= word_idx;
            remaining <= bus.Count;
          end
        end
        SUM: begin
          acc       <= acc + mem[ptr];
          ptr       <= ptr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: combinational from inputs in IDLE, state-driven in SUM/DONE.
  always_comb begin
    bus.ReadData = '0;
    bus.Stall    = 1'b0;
    bus.Done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.MemRead && bus.C_EN)
          bus.Stall = 1'b1;
        else if (bus.MemRead)
          bus.ReadData = mem[word_idx];
      end
      SUM:  bus.Stall = 1'b1;
      DONE: begin
        bus.Done     = 1'b1;
        bus.ReadData = acc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed self-checking bench for mem_stage_access_unit.
module tb_mem_stage_access_unit;

  logic Clk;
  logic Rst;
  int   total;
  int   bad;

  mem_stage_access_unit_if #(.DATA_W(32), .ADDR_W(6)) bus ();

  mem_stage_access_unit #(.DATA_W(32), .ADDR_W(6)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_in();
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.C_EN      = 1'b0;
    bus.Count     = '0;
    bus.Addr      = '0;
    bus.WriteData = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    bus.C_EN      = 1'b0;
    bus.Addr      = addr;
    bus.WriteData = data;
    cyc();
    clear_in();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    bus.C_EN     = 1'b0;
    bus.Addr     = addr;
    settle();
    chk({tag, "_data"}, bus.ReadData, exp);
    chk({tag, "_stall"}, {31'd0, bus.Stall}, 32'd0);
    cyc();
    clear_in();
  endtask

  // Full burst: Stall for cnt+2 cycles, then one DONE cycle with the sum.
  task automatic burst(input string tag, input logic [31:0] addr, input logic [5:0] cnt,
                       input logic [31:0] exp, input bit poke);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    bus.C_EN     = 1'b1;
    bus.Count    = cnt;
    bus.Addr     = addr;
    for (int unsigned i = 0; i < 32'(cnt) + 2; i++) begin
      bus.MemWrite  = poke && (i != 0);
      bus.WriteData = 32'hAAAA_AAAA;
      settle();
      chk({tag, "_stall"}, {31'd0, bus.Stall}, 32'd1);
      chk({tag, "_busy_done"}, {31'd0, bus.Done}, 32'd0);
      chk({tag, "_busy_rd"}, bus.ReadData, 32'd0);
      cyc();
    end
    bus.MemWrite = 1'b0;
    settle();
    chk({tag, "_sum"}, bus.ReadData, exp);
    chk({tag, "_done"}, {31'd0, bus.Done}, 32'd1);
    chk({tag, "_done_stall"}, {31'd0, bus.Stall}, 32'd0);
    cyc();
    clear_in();
    settle();
    chk({tag, "_idle_done"}, {31'd0, bus.Done}, 32'd0);
    chk({tag, "_idle_stall"}, {31'd0, bus.Stall}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Rst   = 1'b0;
    clear_in();
    #2;
    chk("rst_stall", {31'd0, bus.Stall}, 32'd0);
    chk("rst_done", {31'd0, bus.Done}, 32'd0);
    chk("rst_rd", bus.ReadData, 32'd0);
    cyc();
    Rst = 1'b1;
    cyc();

    // Store then load.
    bus.MemWrite  = 1'b1;
    bus.Addr      = 32'h10;
    bus.WriteData = 32'hDEAD_BEEF;
    settle();
    chk("st_stall", {31'd0, bus.Stall}, 32'd0);
    chk("st_rd", bus.ReadData, 32'd0);
    cyc();
    clear_in();
    rd_chk("ld10", 32'h10, 32'hDEAD_BEEF);

    // Block-sum 1+2+3+4.
    wr(32'h0, 32'd1);
    wr(32'h4, 32'd2);
    wr(32'h8, 32'd3);
    wr(32'hC, 32'd4);
    wr(32'h14, 32'd7);
    wr(32'hFC, 32'hFFFF_FFFF);
    burst("sum4", 32'h0, 6'd3, 32'd10, 1'b0);

    // Wrap 63 -> 0 with modular overflow.
    wr(32'h0, 32'd2);
    burst("wrap", 32'hFC, 6'd1, 32'd1, 1'b0);

    // Count=0 sums one word; low address bits are ignored.
    burst("one", 32'h17, 6'd0, 32'd7, 1'b0);

    // Load wins over a simultaneous store.
    wr(32'h8, 32'h55);
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b1;
    bus.Addr      = 32'h8;
    bus.WriteData = 32'h1234;
    settle();
    chk("conf_rd", bus.ReadData, 32'h55);
    cyc();
    clear_in();
    rd_chk("conf_mem", 32'h8, 32'h55);

    // Stores during SUM are ignored.
    wr(32'h4, 32'd2);
    burst("poke", 32'h0, 6'd1, 32'd4, 1'b1);
    rd_chk("poke_w0", 32'h0, 32'd2);
    rd_chk("poke_w1", 32'h4, 32'd2);

    // Reset on the 4th SUM cycle of a Count=10 burst.
    bus.MemRead = 1'b1;
    bus.C_EN    = 1'b1;
    bus.Count   = 6'd10;
    bus.Addr    = 32'h0;
    for (int unsigned i = 0; i < 4; i++) begin
      settle();
      chk("rb_stall", {31'd0, bus.Stall}, 32'd1);
      cyc();
    end
    clear_in();
    Rst = 1'b0;
    settle();
    chk("rb_stall_drop", {31'd0, bus.Stall}, 32'd0);
    chk("rb_done_drop", {31'd0, bus.Done}, 32'd0);
    chk("rb_rd", bus.ReadData, 32'd0);
    cyc();
    Rst = 1'b1;
    cyc();
    burst("fresh", 32'h0, 6'd1, 32'd4, 1'b0);
    rd_chk("fresh_w0", 32'h0, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage_access_unit.md
# mem_stage_access_unit

MEM-stage data-memory unit of the pipelined datapath, fed directly by the EX/MEM pipeline register (MemWrite, MemRead, C_EN, 6-bit Count plus address and store data). It performs single-cycle word loads and stores into a 64-word data memory. When C_EN qualifies a load, it performs a multi-cycle block-sum: it accumulates Count+1 consecutive words and holds the pipeline with Stall until the sum is ready.

## Interface
- DATA_W, 32, data and accumulator width
- ADDR_W, 6, word-address width (memory depth 2^ADDR_W = 64 words)

- Clk  in  1  single clock, rising-edge
- Rst  in  1  asynchronous, active-low reset
- MemWrite  in  1  store request (from EX/MEM register)
- MemRead  in  1  load request
- C_EN  in  1  block-sum qualifier; meaningful only with MemRead
- Count  in  6  block-sum length minus one (N → N+1 words)
- Addr  in  32  byte address; word index = Addr[ADDR_W+1:2], Addr[1:0] ignored
- WriteData  in  32  store data
- ReadData  out  32  load data or block-sum result
- Stall  out  1  hold request to upstream pipeline registers and PC
- Done  out  1  one-cycle pulse when block-sum result is on ReadData

## Operation
- Storage: 64×32 array, not cleared by Rst; contents are undefined until written.
- FSM states: IDLE, SUM, DONE. Registers: state, acc[31:0], ptr[5:0], remaining[5:0].
- IDLE behaviour by request:
  - MemRead=1, C_EN=0: ReadData = mem[word index], combinational. Stall=0.
  - MemWrite=1, MemRead=0: mem[word index] <= WriteData at the edge. ReadData=0. C_EN ignored.
  - MemRead=1, MemWrite=1: load wins and the write is suppressed. If C_EN=1, a block-sum starts.
  - MemRead=1, C_EN=1 (block-sum start): Stall=1 combinationally this cycle. At the edge: ptr <= word index, remaining <= Count, acc <= 0, state <= SUM.
  - No request: ReadData=0, Stall=0.
- SUM:
  - Each edge: acc <= acc + mem[ptr]; ptr <= ptr+1 (mod 64, wraps 63→0); remaining <= remaining−1.
  - When remaining==0 at the edge: the final add is performed and state <= DONE.
  - Stall=1 and ReadData=0 throughout. All write requests are ignored.
- DONE:
  - Stall=0, Done=1, ReadData=acc.
  - Inputs are ignored, so the still-held burst instruction cannot retrigger.
  - Next edge: state <= IDLE.
- Arithmetic: the 32-bit sum wraps modulo 2^32 with no overflow flag.
- Count=0 sums exactly one word. Count=63 sums all 64 words, wrapping from any base.

## Timing
- Reset (Rst=0, asynchronous): state=IDLE, acc=0, ptr=0, remaining=0.
  - Done=0 immediately.
  - Stall and ReadData then follow the IDLE combinational rules.
  - Reset asserted in SUM or DONE aborts the burst with no partial result and writes no memory.
- Load latency: 0 cycles (combinational in IDLE); the downstream MEM/WB register captures at the same edge.
- Store: takes effect at the edge of the request cycle. A load of the same address in the next cycle returns the new data.
- Block-sum with Count=N:
  - Stall is high for N+2 consecutive cycles (start cycle plus N+1 SUM cycles).
  - DONE is the (N+3)th cycle counted from the start cycle, with Stall=0, Done=1 and the result on ReadData.
  - Upstream holds MemRead, C_EN, Count and Addr stable while Stall=1. The unit samples them only in the start cycle.
- Stall is a combinational function of state and inputs in IDLE, and registered-state based in SUM/DONE.

## Test plan
- Store then load: write 0xDEADBEEF to Addr 0x10, then read Addr 0x10 with C_EN=0 → ReadData=0xDEADBEEF the next cycle, Stall=0 in both cycles.
- Block-sum: words 0..3 = 1,2,3,4; MemRead=1, C_EN=1, Count=3, Addr=0 → Stall high 5 cycles, then DONE cycle with ReadData=10, Done=1, Stall=0; back in IDLE the following cycle.
- Wrap and overflow:
  - word 63=0xFFFFFFFF, word 0=2; Count=1, Addr=0xFC → ReadData=1 (mod 2^32), ptr wraps 63→0.
  - Count=0 on word 5=7 → Stall 2 cycles, ReadData=7.
- Conflicts:
  - MemWrite=1 with MemRead=1 on Addr 0x8 holding 0x55 → ReadData=0x55 and the memory is unchanged.
  - MemWrite pulses during SUM → the memory is unchanged after the burst.
- Reset mid-burst: Count=10 started, Rst=0 on the 4th SUM cycle → Stall/Done drop and state is IDLE. A later Count=1 burst at Addr 0 returns the correct fresh sum (acc restarted at 0).
